// File: rtl/timer_pkg.sv
// Shared types and default widths for the timer channel.
package timer_pkg;

  typedef enum logic {
    MODE_UP      = 1'b0,
    MODE_UP_DOWN = 1'b1
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam int CNT_W_DEF = 8;
  localparam int PSC_W_DEF = 8;

endpackage

// File: rtl/timer_prescaler.sv
// Prescale counter: one tick every prescaler_value+1 enabled clocks.
module timer_prescaler #(
  parameter int PRESCALER_BIT_WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           enable,
  input  logic [PRESCALER_BIT_WIDTH-1:0] prescaler_value,
  output logic                           tick
);

  logic [PRESCALER_BIT_WIDTH-1:0] pcnt_q;

  // >= keeps a shrunk divide value from wrapping the whole range
  assign tick = enable && (pcnt_q >= prescaler_value);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcnt_q <= '0;
    end else if (enable) begin
      pcnt_q <= tick ? '0 : pcnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/timer_pwm_controller.sv
// Timer channel: counter, direction, compare/PWM and event pulses.
// Define TIMER_SHADOW_EN for double-buffered period/compare values.
module timer_pwm_controller
  import timer_pkg::*;
#(
  parameter int COUNTER_BIT_WIDTH   = CNT_W_DEF,
  parameter int PRESCALER_BIT_WIDTH = PSC_W_DEF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           enable,
  input  logic                           mode,
  input  logic                           load,
  input  logic [PRESCALER_BIT_WIDTH-1:0] prescaler_value,
  input  logic [COUNTER_BIT_WIDTH-1:0]   period_value,
  input  logic [COUNTER_BIT_WIDTH-1:0]   cmp_0_value,
  input  logic [COUNTER_BIT_WIDTH-1:0]   cmp_1_value,
  output logic [COUNTER_BIT_WIDTH-1:0]   counter,
  output logic                           pwm_out,
  output logic                           cmp_0_event,
  output logic                           cmp_1_event,
  output logic                           period_event
);

  localparam int CW = COUNTER_BIT_WIDTH;
  localparam int PW = PRESCALER_BIT_WIDTH;
  localparam logic [CW-1:0] ONE = 1;

  logic [PW-1:0] act_psc;
  logic [CW-1:0] act_per;
  logic [CW-1:0] act_c0;
  logic [CW-1:0] act_c1;

  logic          tick;
  logic          boundary;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  dir_e          dir_q;
  dir_e          dir_d;
  mode_e         mode_s;
  logic          tick_q;
  logic          bnd_q;
  logic          match_0;
  logic          match_1;

  assign mode_s  = mode_e'(mode);
  assign counter = cnt_q;

  timer_prescaler #(
    .PRESCALER_BIT_WIDTH(PW)
  ) u_psc (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .prescaler_value(act_psc),
    .tick           (tick)
  );

`ifdef TIMER_SHADOW_EN
  logic [PW-1:0] sh_psc;
  logic [CW-1:0] sh_per;
  logic [CW-1:0] sh_c0;
  logic [CW-1:0] sh_c1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_psc  <= '0;
      sh_per  <= '0;
      sh_c0   <= '0;
      sh_c1   <= '0;
      act_psc <= '0;
      act_per <= '0;
      act_c0  <= '0;
      act_c1  <= '0;
    end else begin
      if (load) begin
        sh_psc <= prescaler_value;
        sh_per <= period_value;
        sh_c0  <= cmp_0_value;
        sh_c1  <= cmp_1_value;
      end
      // idle channel tracks shadow so the next start uses fresh values
      if (boundary || !enable) begin
        act_psc <= sh_psc;
        act_per <= sh_per;
        act_c0  <= sh_c0;
        act_c1  <= sh_c1;
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      act_psc <= '0;
      act_per <= '0;
      act_c0  <= '0;
      act_c1  <= '0;
    end else if (load) begin
      act_psc <= prescaler_value;
      act_per <= period_value;
      act_c0  <= cmp_0_value;
      act_c1  <= cmp_1_value;
    end
  end
`endif

  always_comb begin
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    boundary = 1'b0;
    if (tick) begin
      if (mode_s == MODE_UP) begin
        if (cnt_q >= act_per) begin
          cnt_d    = '0;
          boundary = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end else if (act_per == '0) begin
        cnt_d    = '0;
        dir_d    = DIR_UP;
        boundary = 1'b1;
      end else if (dir_q == DIR_UP) begin
        if (cnt_q >= act_per) begin
          cnt_d = cnt_q - ONE;
          dir_d = DIR_DOWN;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end else begin
        if (cnt_q <= ONE) begin
          cnt_d    = '0;
          dir_d    = DIR_UP;
          boundary = 1'b1;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      dir_q  <= DIR_UP;
      tick_q <= 1'b0;
      bnd_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dir_q  <= dir_d;
      tick_q <= tick;
      bnd_q  <= boundary;
    end
  end

  // tick_q marks the one cycle in which a freshly ticked value is compared
  assign match_0 = tick_q && (cnt_q == act_c0);
  assign match_1 = tick_q && (cnt_q == act_c1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwm_out      <= 1'b0;
      cmp_0_event  <= 1'b0;
      cmp_1_event  <= 1'b0;
      period_event <= 1'b0;
    end else begin
      cmp_0_event  <= match_0;
      cmp_1_event  <= match_1;
      period_event <= bnd_q;
      if (match_1) begin
        pwm_out <= 1'b0;
      end else if (match_0) begin
        pwm_out <= 1'b1;
      end
    end
  end

endmodule
